// File: rtl/gpio_pad_ctrl.sv
// rtl/gpio_pad_ctrl.sv - GPIO pad buffer controller: output drive, input resync/filter, edge interrupts
// Optional glitch filter enabled by defining GPIO_FILTER_EN.
module gpio_pad_ctrl #(
  parameter int N     = 8,
  parameter int SYNC  = 2,
  parameter int FILTW = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [N-1:0]     out_data,
  input  logic [N-1:0]     out_en,
  input  logic [N-1:0]     od_mode,
  input  logic [N-1:0]     in_en,
  input  logic [FILTW-1:0] filt_thresh,
  input  logic [N-1:0]     rise_en,
  input  logic [N-1:0]     fall_en,
  input  logic [N-1:0]     irq_mask,
  input  logic [N-1:0]     irq_clr,
  output logic [N-1:0]     in_data,
  output logic [N-1:0]     irq_pend,
  output logic             irq,
  output logic [N-1:0]     dout,
  output logic [N-1:0]     oen,
  output logic [N-1:0]     ie,
  input  logic [N-1:0]     din
);

  logic [N-1:0]           dout_q, dout_d;
  logic [N-1:0]           oen_q, oen_d;
  logic [N-1:0]           ie_q, ie_d;
  logic [N-1:0]           f_q, f_d;
  logic [N-1:0]           pend_q, pend_d;
  logic [SYNC-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0]           s;
  logic [N-1:0]           rise, fall;

  assign s = sync_q[SYNC-1];

  // Open-drain pads only ever pull low: dout stays 0 and oen carries the data.
  always_comb begin
    dout_d = out_data & ~od_mode;
    oen_d  = ~(out_en & ~(out_data & od_mode));
    ie_d   = in_en;
    sync_d[0] = din & ie_q;
    for (int j = 1; j < SYNC; j++) begin
      sync_d[j] = sync_q[j-1] & ie_q;
    end
  end

`ifdef GPIO_FILTER_EN
  logic [N-1:0][FILTW-1:0] cnt_q, cnt_d;

  // cnt >= T flips rather than cnt == T, so lowering the threshold mid-count never stalls.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (!ie_q[i]) begin
        f_d[i]   = 1'b0;
        cnt_d[i] = '0;
      end else if (s[i] == f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < filt_thresh) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        f_d[i]   = ~f_q[i];
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_filt_thresh;

  assign unused_filt_thresh = ^filt_thresh;
  assign f_d = s & ie_q;
`endif

  // Disabled inputs are forced low silently, hence the ie_q gating on both events.
  always_comb begin
    rise   = f_d & ~f_q & ie_q;
    fall   = ~f_d & f_q & ie_q;
    pend_d = (pend_q & ~irq_clr) | (rise & rise_en) | (fall & fall_en);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dout_q <= '0;
      oen_q  <= '1;
      ie_q   <= '0;
      sync_q <= '0;
      f_q    <= '0;
      pend_q <= '0;
    end else begin
      dout_q <= dout_d;
      oen_q  <= oen_d;
      ie_q   <= ie_d;
      sync_q <= sync_d;
      f_q    <= f_d;
      pend_q <= pend_d;
    end
  end

  assign dout     = dout_q;
  assign oen      = oen_q;
  assign ie       = ie_q;
  assign in_data  = f_q;
  assign irq_pend = pend_q;
  assign irq      = |(pend_q & irq_mask);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb/tb_gpio_pad_ctrl.sv - self-checking bench for gpio_pad_ctrl (directed + random vs reference model)
module tb_gpio_pad_ctrl;
  localparam int N     = 8;
  localparam int SYNC  = 2;
  localparam int FILTW = 4;

  logic             clk = 1'b0;
  logic             nreset;
  logic [N-1:0]     out_data, out_en, od_mode, in_en;
  logic [FILTW-1:0] filt_thresh;
  logic [N-1:0]     rise_en, fall_en, irq_mask, irq_clr;
  logic [N-1:0]     in_data, irq_pend, dout, oen, ie, din;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_f, m_pend, m_dout, m_oen, m_ie;
  int           m_run [N];

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.N(N), .SYNC(SYNC), .FILTW(FILTW)) dut (
    .clk(clk), .nreset(nreset), .out_data(out_data), .out_en(out_en), .od_mode(od_mode),
    .in_en(in_en), .filt_thresh(filt_thresh), .rise_en(rise_en), .fall_en(fall_en),
    .irq_mask(irq_mask), .irq_clr(irq_clr), .in_data(in_data), .irq_pend(irq_pend),
    .irq(irq), .dout(dout), .oen(oen), .ie(ie), .din(din)
  );

  function automatic int t_eff();
`ifdef GPIO_FILTER_EN
    return int'(filt_thresh);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_pipe[j] = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_f = '0; m_pend = '0; m_dout = '0; m_oen = '1; m_ie = '0;
  endtask

  // Advances the model by one clock edge from the current inputs, then waits past the edge.
  task automatic tick();
    logic [N-1:0] nf, ev_r, ev_f;
    int te;
    te = t_eff();
    if (!nreset) begin
      model_reset();
    end else begin
      nf = m_f;
      for (int i = 0; i < N; i++) begin
        if (!m_ie[i]) begin
          nf[i] = 1'b0;
          m_run[i] = 0;
        end else if (m_pipe[SYNC-1][i] != m_f[i]) begin
          if (m_run[i] + 1 >= te + 1) begin
            nf[i] = ~m_f[i];
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      ev_r = nf & ~m_f & m_ie;
      ev_f = ~nf & m_f & m_ie;
      m_pend = (m_pend & ~irq_clr) | (ev_r & rise_en) | (ev_f & fall_en);
      for (int j = SYNC - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1] & m_ie;
      m_pipe[0] = din & m_ie;
      m_f = nf;
      for (int i = 0; i < N; i++) begin
        if (od_mode[i]) begin
          m_dout[i] = 1'b0;
          m_oen[i]  = !(out_en[i] && !out_data[i]);
        end else begin
          m_dout[i] = out_data[i];
          m_oen[i]  = !out_en[i];
        end
      end
      m_ie = in_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      out_data = $urandom; out_en = $urandom; od_mode = $urandom; in_en = $urandom;
      din = $urandom; rise_en = $urandom; fall_en = $urandom; irq_mask = $urandom;
      irq_clr = $urandom; filt_thresh = $urandom;
      tick();
    end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_checks++; if (oen !== 8'hFF) begin n_fail++; $display("FAIL reset_oen: got %h expected ff", oen); end
    n_checks++; if (ie !== 8'h00) begin n_fail++; $display("FAIL reset_ie: got %h expected 00", ie); end
    n_checks++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL reset_in_data: got %h expected 00", in_data); end
    n_checks++; if (irq_pend !== 8'h00) begin n_fail++; $display("FAIL reset_pend: got %h expected 00", irq_pend); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    out_data = 8'h3C; out_en = 8'hFF; od_mode = 8'h00; in_en = 8'hFF; din = 8'h00;
    rise_en = 8'h00; fall_en = 8'h00; irq_mask = 8'h00; irq_clr = 8'h00; filt_thresh = 4'd1;
    nreset = 1'b1;
    tick();
    n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL release_dout: got %h expected 3c", dout); end
    n_checks++; if (oen !== 8'h00) begin n_fail++; $display("FAIL release_oen: got %h expected 00", oen); end
    n_checks++; if (ie !== 8'hFF) begin n_fail++; $display("FAIL release_ie: got %h expected ff", ie); end
  endtask

  task automatic test_drive_modes();
    out_en = 8'hFF; out_data = 8'hA5; od_mode = 8'h00;
    tick();
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL pp_dout: got %h expected a5", dout); end
    n_checks++; if (oen !== 8'h00) begin n_fail++; $display("FAIL pp_oen: got %h expected 00", oen); end
    od_mode = 8'hFF;
    tick();
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL od_dout: got %h expected 00", dout); end
    n_checks++; if (oen !== 8'hA5) begin n_fail++; $display("FAIL od_oen: got %h expected a5", oen); end
  endtask

`ifdef GPIO_FILTER_EN
  task automatic test_filter();
    filt_thresh = 4'd3; in_en = 8'hFF; din = 8'h00;
    settle(10);
    din[0] = 1'b1;
    settle(3);
    din[0] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_checks++;
      if (in_data[0] !== 1'b0) begin n_fail++; $display("FAIL filt_pulse_reject e=%0d: got %b expected 0", e, in_data[0]); end
    end
    din[0] = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      n_checks++;
      if (in_data[0] !== (e == 5)) begin n_fail++; $display("FAIL filt_t3_latency e=%0d: got %b expected %b", e, in_data[0], e == 5); end
    end
    din[0] = 1'b0;
    settle(10);
    filt_thresh = 4'd0;
    din[0] = 1'b1;
    for (int e = 0; e <= 2; e++) begin
      tick();
      n_checks++;
      if (in_data[0] !== (e == 2)) begin n_fail++; $display("FAIL filt_t0_latency e=%0d: got %b expected %b", e, in_data[0], e == 2); end
    end
    din[0] = 1'b0;
    settle(4);
  endtask
`else
  task automatic test_no_filter();
    filt_thresh = 4'd7; in_en = 8'hFF; din = 8'h00;
    settle(6);
    din[1] = 1'b1;
    tick();
    din[1] = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      n_checks++;
      if (in_data[1] !== (e == 2)) begin n_fail++; $display("FAIL nofilt_pulse e=%0d: got %b expected %b", e, in_data[1], e == 2); end
      tick();
    end
  endtask
`endif

  task automatic test_irq();
    int lat;
    filt_thresh = 4'd1; in_en = 8'hFF; din = 8'h00;
    rise_en = 8'h04; fall_en = 8'h00; irq_mask = 8'h04;
    settle(8);
    irq_clr = 8'hFF; tick(); irq_clr = 8'h00;
    lat = SYNC + t_eff();
    din[2] = 1'b1;
    for (int e = 0; e <= lat; e++) begin
      tick();
      n_checks++;
      if ({in_data[2], irq_pend[2], irq} !== {3{e == lat}}) begin
        n_fail++; $display("FAIL irq_rise e=%0d: got in/pend/irq=%b%b%b expected all %b", e, in_data[2], irq_pend[2], irq, e == lat);
      end
    end
    irq_clr[2] = 1'b1; tick(); irq_clr = 8'h00;
    n_checks++; if (irq_pend[2] !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got pend=%b irq=%b expected 0 0", irq_pend[2], irq); end
    fall_en = 8'h04;
    din[2] = 1'b0;
    for (int e = 0; e <= lat; e++) begin
      if (e == lat) irq_clr[2] = 1'b1;
      tick();
    end
    irq_clr = 8'h00;
    n_checks++; if (irq_pend[2] !== 1'b1 || in_data[2] !== 1'b0) begin n_fail++; $display("FAIL irq_set_wins: got pend=%b in=%b expected 1 0", irq_pend[2], in_data[2]); end
    irq_clr[2] = 1'b1; tick(); irq_clr = 8'h00;
    n_checks++; if (irq_pend[2] !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear_alone: got pend=%b irq=%b expected 0 0", irq_pend[2], irq); end
  endtask

  task automatic test_input_disable();
    rise_en = 8'h00; fall_en = 8'h10; irq_mask = 8'h10; in_en = 8'hFF;
    din[4] = 1'b1;
    settle(SYNC + t_eff() + 3);
    irq_clr = 8'hFF; tick(); irq_clr = 8'h00;
    n_checks++; if (in_data[4] !== 1'b1) begin n_fail++; $display("FAIL dis_pre_in: got %b expected 1", in_data[4]); end
    in_en[4] = 1'b0;
    settle(3);
    n_checks++; if (in_data[4] !== 1'b0) begin n_fail++; $display("FAIL dis_in_data: got %b expected 0", in_data[4]); end
    n_checks++; if (irq_pend[4] !== 1'b0) begin n_fail++; $display("FAIL dis_pend: got %b expected 0", irq_pend[4]); end
    n_checks++; if (ie[4] !== 1'b0) begin n_fail++; $display("FAIL dis_ie: got %b expected 0", ie[4]); end
    in_en = 8'hFF;
    din[4] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      out_data = $urandom; out_en = $urandom; od_mode = $urandom;
      din = din ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) in_en = in_en ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) filt_thresh = $urandom;
      if ($urandom_range(0, 15) == 0) begin rise_en = $urandom; fall_en = $urandom; irq_mask = $urandom; end
      irq_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      nreset = ($urandom_range(0, 199) != 0);
      tick();
      n_checks++;
      if ({dout, oen, ie} !== {m_dout, m_oen, m_ie}) begin
        n_fail++; $display("FAIL rnd_out c=%0d: got dout/oen/ie=%h/%h/%h expected %h/%h/%h", c, dout, oen, ie, m_dout, m_oen, m_ie);
      end
      n_checks++;
      if (in_data !== m_f) begin n_fail++; $display("FAIL rnd_in_data c=%0d: got %h expected %h", c, in_data, m_f); end
      n_checks++;
      if (irq_pend !== m_pend) begin n_fail++; $display("FAIL rnd_pend c=%0d: got %h expected %h", c, irq_pend, m_pend); end
      n_checks++;
      if (irq !== |(m_pend & irq_mask)) begin n_fail++; $display("FAIL rnd_irq c=%0d: got %b expected %b", c, irq, |(m_pend & irq_mask)); end
    end
    nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_drive_modes();
`ifdef GPIO_FILTER_EN
    test_filter();
`else
    test_no_filter();
`endif
    test_irq();
    test_input_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
